// File: rtl/scramble_sequencer_pkg.sv
// Shared constants and types for the cube scramble sequencer: move-code fields,
// FSM state encoding and the 16-bit Galois LFSR step function.
package scramble_pkg;

    localparam logic [2:0] FACE_U = 3'd0;
    localparam logic [2:0] FACE_D = 3'd1;
    localparam logic [2:0] FACE_F = 3'd2;
    localparam logic [2:0] FACE_B = 3'd3;
    localparam logic [2:0] FACE_L = 3'd4;
    localparam logic [2:0] FACE_R = 3'd5;

    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    localparam logic [3:0] NUM_MOVE_CODES = 4'd12;
    localparam logic [3:0] MOVE_NONE      = 4'hF;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        PICK      = 2'd2,
        ISSUE     = 2'd3
    } state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    function automatic logic [3:0] move_inverse(input logic [3:0] m);
        return m ^ 4'h1;
    endfunction

endpackage

// File: rtl/scramble_sequencer_lfsr16.sv
// Free-running 16-bit Galois LFSR; an all-zero seed is replaced by 1 so the
// register can never lock up.
module lfsr16
    import scramble_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_d;
    logic [15:0] q_q;

    always_comb begin
        q_d = lfsr_next(q_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/scramble_sequencer.sv
// Shares the cube-state move port between user moves and an LFSR scrambler.
// Define SCRAMBLE_UNDO_FILTER_EN to forbid a scramble move directly undoing the previous one.
module scramble_sequencer
    import scramble_pkg::*;
#(
    parameter int unsigned  NUM_MOVES = 20,
    parameter logic [15:0]  LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic       user_move_valid,
    input  logic [3:0] user_move,
    output logic       user_move_ready,
    output logic       move_valid,
    output logic [3:0] move,
    input  logic       move_ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] count
);

`ifdef SCRAMBLE_UNDO_FILTER_EN
    localparam logic UNDO_FILTER = 1'b1;
`else
    localparam logic UNDO_FILTER = 1'b0;
`endif

    localparam logic [7:0] LAST_COUNT = 8'(NUM_MOVES);

    logic [15:0] lfsr;
    logic        lfsr_unused;
    logic [3:0]  cand;
    logic        accept;

    state_e      state_d, state_q;
    logic [3:0]  move_d, move_q;
    logic [3:0]  last_d, last_q;
    logic [7:0]  count_d, count_q;
    logic        busy_d, busy_q;
    logic        done_d, done_q;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .q     (lfsr)
    );

    assign cand        = lfsr[3:0];
    assign lfsr_unused = ^lfsr[15:4];
    // last_q == MOVE_NONE makes the inverse 4'hE, which is never a legal candidate
    assign accept      = (cand < NUM_MOVE_CODES) &&
                         (!UNDO_FILTER || (cand != move_inverse(last_q)));

    always_comb begin
        state_d = state_q;
        move_d  = move_q;
        last_d  = last_q;
        count_d = count_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_TICK;
                    count_d = 8'd0;
                    last_d  = MOVE_NONE;
                end
            end
            WAIT_TICK: begin
                if (tick) begin
                    state_d = PICK;
                end
            end
            PICK: begin
                if (accept) begin
                    move_d  = cand;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (move_ready) begin
                    last_d  = move_q;
                    count_d = (count_q == LAST_COUNT) ? count_q : count_q + 8'd1;
                    if (count_q + 8'd1 == LAST_COUNT) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_TICK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            move_q  <= MOVE_NONE;
            last_q  <= MOVE_NONE;
            count_q <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            move_q  <= move_d;
            last_q  <= last_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Idle passthrough is combinational so user moves see no extra latency
    assign move_valid      = (state_q == IDLE) ? user_move_valid : (state_q == ISSUE);
    assign move            = (state_q == IDLE) ? user_move : move_q;
    assign user_move_ready = (state_q == IDLE) && move_ready;
    assign busy            = busy_q;
    assign done            = done_q;
    assign count           = count_q;

endmodule

// File: tb/tb_scramble_sequencer.sv
// Directed bench for scramble_sequencer with an LFSR reference model and a
// queue of expected scramble move codes.
module tb_scramble_sequencer;

    localparam int          NM   = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       start;
    logic       user_move_valid;
    logic [3:0] user_move;
    logic       user_move_ready;
    logic       move_valid;
    logic [3:0] move;
    logic       move_ready;
    logic       busy;
    logic       done;
    logic [7:0] count;

    scramble_sequencer #(
        .NUM_MOVES (NM),
        .LFSR_SEED (SEED)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tick            (tick),
        .start           (start),
        .user_move_valid (user_move_valid),
        .user_move       (user_move),
        .user_move_ready (user_move_ready),
        .move_valid      (move_valid),
        .move            (move),
        .move_ready      (move_ready),
        .busy            (busy),
        .done            (done),
        .count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int done_cnt   = 0;
    int inv_pairs  = 0;
    bit filt;

    logic [15:0] m_lfsr;
    logic [3:0]  m_last;
    logic [3:0]  q_exp[$];

    function automatic logic [15:0] nxt(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= nxt(m_lfsr);
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic move_once(input int gap, input int stall, input bit tick_in_stall,
                             output logic [3:0] code);
        logic [15:0] c;
        logic [3:0]  e;
        logic [7:0]  cnt0;
        int k;
        int n;
        repeat (gap) step();
        chk("gap_no_valid", move_valid, 0);
        chk("gap_user_locked", user_move_ready, 0);
        c = nxt(m_lfsr);
        k = 0;
        while (!((c[3:0] < 4'd12) && (!filt || c[3:0] != (m_last ^ 4'h1)))) begin
            c = nxt(c);
            k++;
        end
        q_exp.push_back(c[3:0]);
        move_ready = (stall == 0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        n = 1;
        while (move_valid !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("tick_latency", n, 2 + k);
        cnt0 = count;
        code = move;
        chk("code_legal", code < 4'd12, 1);
        for (int i = 0; i < stall; i++) begin
            if (tick_in_stall && i == stall / 2) tick = 1'b1;
            step();
            tick = 1'b0;
            chk("stall_move", move, code);
            chk("stall_valid", move_valid, 1);
            chk("stall_count", count, cnt0);
        end
        move_ready = 1'b1;
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            chk("move_code", move, e);
        end else begin
            chk("queue_nonempty", 0, 1);
        end
        chk("issue_user_locked", user_move_ready, 0);
        step();
        chk("count_inc", count, cnt0 + 8'd1);
        m_last = code;
    endtask

    task automatic start_scramble(input bit tick_with_start);
        start = 1'b1;
        tick  = tick_with_start;
        step();
        start = 1'b0;
        tick  = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_count", count, 0);
        m_last = 4'hF;
    endtask

    task automatic run_scramble(input int gap, input int stall_at, input bit tick_with_start,
                                input bit rand_gap);
        int d0;
        int g;
        logic [3:0] prev;
        logic [3:0] code;
        d0 = done_cnt;
        prev = 4'hF;
        start_scramble(tick_with_start);
        for (int i = 0; i < NM; i++) begin
            g = rand_gap ? int'($urandom_range(0, 3)) : gap;
            move_once(g, (i == stall_at) ? 10 : 0, i == stall_at, code);
            if (i > 0 && code == (prev ^ 4'h1)) inv_pairs++;
            prev = code;
            if (i < NM - 1) begin
                chk("mid_busy", busy, 1);
                chk("mid_done", done, 0);
            end
        end
        chk("done_high", done, 1);
        chk("done_busy_low", busy, 0);
        chk("done_count", count, NM);
        chk("done_user_ready", user_move_ready, user_move_valid ? 1 : move_ready);
        chk("done_passthrough", move, user_move);
        step();
        chk("done_one_cycle", done, 0);
        step();
        chk("done_pulses", done_cnt, d0 + 1);
    endtask

    initial begin
        logic [3:0] code;
        int d0;
`ifdef SCRAMBLE_UNDO_FILTER_EN
        filt = 1'b1;
`else
        filt = 1'b0;
`endif
        rst_n = 1'b0;
        tick = 1'b0;
        start = 1'b0;
        user_move_valid = 1'b1;
        user_move = 4'd5;
        move_ready = 1'b1;
        m_last = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_move", move, 5);
            chk("rst_valid", move_valid, 1);
            chk("rst_user_ready", user_move_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_count", count, 0);
        end
        rst_n = 1'b1;
        step();

        // tick coincident with start must be ignored; ticks roughly every 50 cycles
        run_scramble(49, -1, 1'b1, 1'b0);

        // backpressure with a tick dropped during the stall
        user_move_valid = 1'b0;
        run_scramble(2, 1, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            user_move_valid = i[0];
            user_move = 4'(3 * i + 2);
            move_ready = (i != 1);
            step();
            chk("idle_valid", move_valid, i[0]);
            chk("idle_move", move, 3 * i + 2);
            chk("idle_ready", user_move_ready, i != 1);
        end
        move_ready = 1'b1;
        user_move_valid = 1'b1;

        // reset in the middle of a scramble
        d0 = done_cnt;
        start_scramble(1'b0);
        move_once(1, 0, 1'b0, code);
        move_once(1, 0, 1'b0, code);
        chk("mid_count2", count, 2);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_count", count, 0);
        chk("abort_passthrough", move_valid, 1);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("abort_no_done", done_cnt, d0);
        chk("abort_queue_empty", q_exp.size(), 0);
        run_scramble(3, -1, 1'b0, 1'b0);

        inv_pairs = 0;
        user_move_valid = 1'b0;
        for (int s = 0; s < 150; s++) begin
            run_scramble(0, -1, 1'b0, 1'b1);
        end
        if (filt) chk("undo_pairs_none", inv_pairs, 0);
        else      chk("undo_pairs_seen", inv_pairs > 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
